fir_coef_loader: RTL and testbench
==================================

Name: fir_coef_loader

Overview:
- Writer side of the equalizer FIR coefficient interface.
- Accepts a serial stream of tap coefficients over a valid/ready handshake and assembles them in a shadow bank.
- On a correctly framed load, commits all taps to the active bank in one cycle, which drives the filter's parallel coefficient inputs.
- The filter never sees a partially loaded coefficient set.

Parameters:
TAPS, 16, number of filter taps (even, >=2)
COEF_W, 16, signed coefficient width in bits
IDX_W, $clog2(TAPS), width of the tap index counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous reset, active low
cfg_valid  input  1  upstream coefficient beat valid
cfg_data  input  COEF_W  signed coefficient; first beat = tap 0
cfg_last  input  1  marks final beat of a load frame
cfg_ready  output  1  loader can accept a beat
coef_flat  output  TAPS*COEF_W  active coefficients; tap k at bits [k*COEF_W +: COEF_W]
coef_update  output  1  one-cycle pulse when the active bank changes
load_err  output  1  one-cycle pulse on a malformed frame
busy  output  1  high while a frame is in progress (LOAD, DRAIN, COMMIT)

Behaviour:
- Reset (async assert, sync release): state=IDLE, idx=0, shadow and active banks all 0. Outputs: coef_flat=0, coef_update=0, load_err=0, busy=0, cfg_ready=1.
- A beat transfers when cfg_valid && cfg_ready at a rising edge. Upstream holds data/last stable while valid && !ready.
- States:
  - IDLE: on beat, write shadow[0], idx<=1. If cfg_last: error path (see below), else go to LOAD.
  - LOAD: on beat, write shadow[idx], idx<=idx+1.
    - If idx==TAPS-1 and cfg_last: go to COMMIT.
    - If cfg_last and idx<TAPS-1 (short frame): load_err pulse, go to IDLE, shadow discarded.
    - If idx==TAPS-1 and !cfg_last (long frame): load_err pulse, go to DRAIN.
  - DRAIN: cfg_ready=1. Beats are discarded until the one with cfg_last, then go to IDLE.
  - COMMIT: cfg_ready=0 for exactly one cycle. Active bank <= shadow, coef_update=1 in this cycle, then go to IDLE.
- Latency: the new coefficients appear on coef_flat one cycle after the last beat's acceptance edge. coef_update is asserted coincident with the new coef_flat value.
- Error handling: on any error the active bank is untouched and idx returns to 0. A 1-beat frame with TAPS>1 is a short-frame error taken directly from IDLE.
- No arithmetic on data; widths are passed through unchanged. idx never exceeds TAPS-1 (it saturates in DRAIN).
- Back-to-back frames: a new frame may start in the cycle after COMMIT. Gaps (cfg_valid low) are allowed anywhere mid-frame and do not change state.
- Reset mid-frame: everything returns to reset values, including the active bank.

Optional Feature:
- Macro COEF_SYM_EN.
- When defined (linear-phase mode): a frame is TAPS/2 beats, loading taps 0..TAPS/2-1. On COMMIT, active[k] and active[TAPS-1-k] both get shadow[k]. Frame-length checks use TAPS/2 in place of TAPS.
- When undefined: full TAPS-beat frames as above, and no mirroring logic is synthesized.

Test Plan:
- Reset then idle -> coef_flat=0, cfg_ready=1, busy=0, no pulses.
- 16 beats 1..16, last on beat 16, valid held high -> one cycle later coef_flat tap k = k+1, coef_update pulse of width 1, cfg_ready low for exactly that COMMIT cycle.
- After a good load of 1..16, send a 5-beat frame of 0x7FFF with last on beat 5 -> load_err pulse after beat 5, coef_flat still 1..16, no coef_update.
- 20-beat frame with last on beat 20 -> load_err after beat 16, beats 17-20 accepted and discarded, back in IDLE, active bank unchanged. A following good frame of all -1 (0xFFFF) commits normally.
- Good frame with random cfg_valid gaps and rst_n pulsed low after beat 9 -> all outputs 0 immediately. The next clean frame loads correctly starting from tap 0.
- With COEF_SYM_EN: 8 beats 10..17 -> tap k and tap 15-k both equal 10+k (tap0=tap15=10, tap7=tap8=17). A 16-beat frame -> load_err.

Source files
------------

// File: rtl/fir_coef_loader.sv
// Serial-to-parallel FIR coefficient loader: shadow bank fills beat by beat, active bank swaps atomically.
// Optional linear-phase (mirrored, half-length frame) mode is enabled by defining COEF_SYM_EN.
module fir_coef_loader #(
  parameter int TAPS   = 16,
  parameter int COEF_W = 16,
  parameter int IDX_W  = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  input  logic [COEF_W-1:0]        cfg_data,
  input  logic                     cfg_last,
  output logic                     cfg_ready,
  output logic [TAPS*COEF_W-1:0]   coef_flat,
  output logic                     coef_update,
  output logic                     load_err,
  output logic                     busy
);

`ifdef COEF_SYM_EN
  localparam int N = TAPS / 2;
`else
  localparam int N = TAPS;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              load_err_reg, err_next;
  logic              wr_en, commit_now, beat;

  logic [COEF_W-1:0] shadow_reg  [N];
  logic [COEF_W-1:0] shadow_next [N];
  logic [COEF_W-1:0] active_reg  [TAPS];
  logic [COEF_W-1:0] commit_bank [TAPS];

  assign cfg_ready   = (state_reg != COMMIT);
  assign beat        = cfg_valid && cfg_ready;
  assign coef_update = (state_reg == COMMIT);
  assign busy        = (state_reg != IDLE);
  assign load_err    = load_err_reg;

  // The final beat is merged into the bank on its own acceptance edge, so the
  // new set is already on coef_flat during the COMMIT cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_shadow
      assign shadow_next[gi] = (wr_en && idx_reg == IDX_W'(gi)) ? cfg_data : shadow_reg[gi];
    end
    for (gi = 0; gi < TAPS; gi++) begin : g_bank
`ifdef COEF_SYM_EN
      localparam int SRC = (gi < N) ? gi : TAPS - 1 - gi;
      assign commit_bank[gi] = shadow_next[SRC];
`else
      assign commit_bank[gi] = shadow_next[gi];
`endif
      assign coef_flat[gi*COEF_W +: COEF_W] = active_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    err_next   = 1'b0;
    commit_now = 1'b0;
    wr_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (beat) begin
          wr_en = 1'b1;
          if (N == 1) begin
            idx_next = '0;
            if (cfg_last) begin
              commit_now = 1'b1;
              state_next = COMMIT;
            end else begin
              err_next   = 1'b1;
              state_next = DRAIN;
            end
          end else if (cfg_last) begin
            err_next   = 1'b1;
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            idx_next   = IDX_W'(1);
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          wr_en = 1'b1;
          if (idx_reg == LAST_IDX) begin
            idx_next = '0;
            if (cfg_last) begin
              commit_now = 1'b1;
              state_next = COMMIT;
            end else begin
              err_next   = 1'b1;
              state_next = DRAIN;
            end
          end else if (cfg_last) begin
            err_next   = 1'b1;
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (beat && cfg_last) state_next = IDLE;
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      load_err_reg <= 1'b0;
      for (int i = 0; i < N; i++) shadow_reg[i] <= '0;
      for (int i = 0; i < TAPS; i++) active_reg[i] <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      load_err_reg <= err_next;
      for (int i = 0; i < N; i++) shadow_reg[i] <= shadow_next[i];
      if (commit_now) begin
        for (int i = 0; i < TAPS; i++) active_reg[i] <= commit_bank[i];
      end
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed-sequence bench for fir_coef_loader with randomized data and a frame-level reference model.
module tb_fir_coef_loader;
  localparam int TAPS   = 16;
  localparam int COEF_W = 16;
  localparam int W      = TAPS * COEF_W;
`ifdef COEF_SYM_EN
  localparam int N = TAPS / 2;
`else
  localparam int N = TAPS;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_last = 1'b0;
  logic [COEF_W-1:0] cfg_data = '0;
  logic              cfg_ready, coef_update, load_err, busy;
  logic [W-1:0]      coef_flat;

  logic [W-1:0]      exp_flat = '0;
  logic [COEF_W-1:0] frame [$];
  int compared = 0;
  int mismatched = 0;
  int upd_cnt = 0, err_cnt = 0, nrdy_cnt = 0;

  always #5 clk = ~clk;

  fir_coef_loader #(.TAPS(TAPS), .COEF_W(COEF_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_last(cfg_last), .cfg_ready(cfg_ready),
    .coef_flat(coef_flat), .coef_update(coef_update), .load_err(load_err), .busy(busy)
  );

  // Pulse and ready-low cycle counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (coef_update) upd_cnt++;
    if (load_err) err_cnt++;
    if (!cfg_ready) nrdy_cnt++;
  end

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [COEF_W-1:0] d, input logic l, input int gap);
    int waited;
    waited = 0;
    repeat (gap) tick();
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    while (!cfg_ready && waited < 8) begin
      tick();
      waited++;
    end
    if (!cfg_ready) check_bit("ready_timeout", cfg_ready, 1'b1);
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // Reference bank: tap k takes frame beat k (mirrored around the centre in linear-phase mode).
  function automatic logic [W-1:0] model_bank();
    logic [W-1:0] r;
    int src;
    r = '0;
    for (int k = 0; k < TAPS; k++) begin
      src = k;
`ifdef COEF_SYM_EN
      if (k >= N) src = TAPS - 1 - k;
`endif
      r[k*COEF_W +: COEF_W] = frame[src];
    end
    return r;
  endfunction

  task automatic run_frame(input string tag, input int maxgap, input bit settle);
    int u0, e0, r0, n;
    bit good;
    u0 = upd_cnt; e0 = err_cnt; r0 = nrdy_cnt;
    n = frame.size();
    good = (n == N);
    for (int b = 0; b < n; b++) begin
      send_beat(frame[b], b == n - 1, (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
      if (b == N - 1 && n > N) begin
        check_bit({tag, "_long_err"}, load_err, 1'b1);
        check_bit({tag, "_drain_busy"}, busy, 1'b1);
      end
      if (b == n - 1) begin
        if (good) begin
          exp_flat = model_bank();
          check_bit({tag, "_update"}, coef_update, 1'b1);
          check_bit({tag, "_commit_ready"}, cfg_ready, 1'b0);
        end else if (n < N) begin
          check_bit({tag, "_short_err"}, load_err, 1'b1);
          check_bit({tag, "_short_idle"}, busy, 1'b0);
        end else begin
          check_bit({tag, "_drain_done"}, busy, 1'b0);
        end
        check_vec({tag, "_flat_last"}, coef_flat, exp_flat);
      end
    end
    if (settle) begin
      repeat (2) tick();
      check_int({tag, "_upd_pulses"}, upd_cnt - u0, good ? 1 : 0);
      check_int({tag, "_err_pulses"}, err_cnt - e0, good ? 0 : 1);
      check_int({tag, "_ready_low"}, nrdy_cnt - r0, good ? 1 : 0);
      check_bit({tag, "_idle_busy"}, busy, 1'b0);
      check_vec({tag, "_flat_settled"}, coef_flat, exp_flat);
    end
  endtask

  initial begin
    int u0, k;
    repeat (3) tick();
    check_vec("rst_flat", coef_flat, '0);
    check_bit("rst_ready", cfg_ready, 1'b1);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_update", coef_update, 1'b0);
    check_bit("rst_err", load_err, 1'b0);
    rst_n = 1'b1;
    repeat (4) tick();
    check_int("idle_pulses", upd_cnt + err_cnt, 0);
    check_vec("idle_flat", coef_flat, '0);

    frame = {};
    for (int i = 0; i < N; i++) frame.push_back(COEF_W'(i + 1));
    run_frame("seq", 0, 1);

    frame = {};
    for (int i = 0; i < 5; i++) frame.push_back(16'h7FFF);
    run_frame("short5", 0, 1);

    frame = {};
    frame.push_back(16'h1234);
    run_frame("short1", 0, 1);

    frame = {};
    for (int i = 0; i < N + 4; i++) frame.push_back(COEF_W'($urandom));
    run_frame("long", 0, 1);

    frame = {};
    for (int i = 0; i < N; i++) frame.push_back(16'hFFFF);
    run_frame("neg1", 0, 1);

    frame = {};
    for (int i = 0; i < N; i++) frame.push_back(COEF_W'($urandom));
    run_frame("gaps", 3, 1);

    // Reset in the middle of a frame clears both banks immediately.
    k = (N > 9) ? 9 : N - 1;
    for (int i = 0; i < k; i++) send_beat(COEF_W'($urandom), 1'b0, $urandom_range(0, 2));
    rst_n = 1'b0;
    #1;
    exp_flat = '0;
    check_vec("midrst_flat", coef_flat, '0);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_ready", cfg_ready, 1'b1);
    check_bit("midrst_update", coef_update, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    frame = {};
    for (int i = 0; i < N; i++) frame.push_back(COEF_W'($urandom));
    run_frame("post_rst", 2, 1);

    // Two good frames back to back; the second starts right after COMMIT.
    u0 = upd_cnt;
    frame = {};
    for (int i = 0; i < N; i++) frame.push_back(COEF_W'($urandom));
    run_frame("b2b_a", 0, 0);
    frame = {};
    for (int i = 0; i < N; i++) frame.push_back(COEF_W'($urandom));
    run_frame("b2b_b", 0, 0);
    repeat (2) tick();
    check_int("b2b_upd_pulses", upd_cnt - u0, 2);
    check_vec("b2b_flat", coef_flat, exp_flat);

    for (int r = 0; r < 4; r++) begin
      frame = {};
      k = $urandom_range(1, N + 3);
      for (int i = 0; i < k; i++) frame.push_back(COEF_W'($urandom));
      run_frame($sformatf("rand%0d_len%0d", r, k), 2, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
